// File: rtl/dmem_lsu_pkg.sv
// Shared constants for the load/store unit: word width, RISC-V load/store funct3
// codes and the access legality check used at request accept.
package dmem_lsu_pkg;

    localparam int WORD_LEN = 32;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Stores only exist as B/H/W; loads have no 011/110/111 encodings.
    function automatic logic lsu_bad(input logic wen, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        illegal    = wen ? (funct3 > LSU_W)
                         : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        misaligned = ((funct3 == LSU_H || funct3 == LSU_HU) && addr_lo[0]) ||
                     (funct3 == LSU_W && addr_lo != 2'b00);
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// Little-endian lane logic: extracts and extends a load value from a memory word,
// and merges sub-word store data into a word for read-modify-write.
module lsu_lane
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic [1:0]          addr,
    input  logic [WORD_LEN-1:0] word,
    input  logic [WORD_LEN-1:0] wdata,
    output logic [WORD_LEN-1:0] load,
    output logic [WORD_LEN-1:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = word[{addr, 3'b000} +: 8];
        half_val = word[{addr[1], 4'b0000} +: 16];
    end

    always_comb begin
        load = '0;
        case (funct3)
            LSU_B:   load = {{(WORD_LEN-8){byte_val[7]}}, byte_val};
            LSU_BU:  load = {{(WORD_LEN-8){1'b0}}, byte_val};
            LSU_H:   load = {{(WORD_LEN-16){half_val[15]}}, half_val};
            LSU_HU:  load = {{(WORD_LEN-16){1'b0}}, half_val};
            LSU_W:   load = word;
            default: load = '0;
        endcase
    end

    always_comb begin
        merged = wdata;
        case (funct3)
            LSU_B: begin
                merged = word;
                merged[{addr, 3'b000} +: 8] = wdata[7:0];
            end
            LSU_H: begin
                merged = word;
                merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store unit in front of a word-wide synchronous data memory.
// Sub-word stores are done as read-modify-write; bad accesses complete with an error.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic [WORD_LEN-1:0] dmem_addr,
    input  logic [WORD_LEN-1:0] dmem_rdata,
    output logic                dmem_wen,
    output logic [WORD_LEN-1:0] dmem_wdata
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

    state_t              state, state_nxt;
    logic                wen_q;
    logic [2:0]          funct3_q;
    logic [1:0]          addr_lo_q;
    logic [WORD_LEN-1:0] wdata_q;
    logic [2:0]          cnt;
    logic                accept;
    logic                bad;
    logic [WORD_LEN-1:0] load_val;
    logic [WORD_LEN-1:0] merged;

    assign req_ready  = (state == IDLE);
    assign dmem_wen   = (state == WRITE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign bad        = lsu_bad(req_wen, req_funct3, req_addr[1:0]);

    lsu_lane u_lane (
        .funct3 (funct3_q),
        .addr   (addr_lo_q),
        .word   (dmem_rdata),
        .wdata  (wdata_q),
        .load   (load_val),
        .merged (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad)                                state_nxt = RESP;
                    else if (req_wen && req_funct3 == LSU_W) state_nxt = WRITE;
                    else                                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: if (cnt == 3'd0) state_nxt = wen_q ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // dmem_wdata is preloaded with the store data at accept so a full-word store
    // can write on the very next cycle; RMW overwrites it with the merged word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q      <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                wen_q      <= req_wen;
                funct3_q   <= req_funct3;
                addr_lo_q  <= req_addr[1:0];
                wdata_q    <= req_wdata;
                cnt        <= 3'(RD_LAT);
                dmem_addr  <= {req_addr[WORD_LEN-1:2], 2'b00};
                dmem_wdata <= req_wdata;
                resp_rdata <= '0;
                resp_err   <= bad;
            end else if (state == RD_WAIT) begin
                if (cnt != 3'd0)  cnt        <= cnt - 3'd1;
                else if (wen_q)   dmem_wdata <= merged;
                else              resp_rdata <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu (RD_LAT=1) with a 1-cycle-read word memory model,
// a vector table and a response scoreboard.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_rdata;
    logic        dmem_wen;
    logic [31:0] dmem_wdata;

    dmem_lsu #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_wen(dmem_wen),
        .dmem_wdata(dmem_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (dmem_wen) mem[dmem_addr[9:2]] <= dmem_wdata;
        dmem_rdata <= mem[dmem_addr[9:2]];
    end

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wcyc;
        logic [31:0] wdat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nmis = 0;

    function automatic vec_t mk(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic err, input int lat, input int wcyc,
                                input logic [31:0] wdat);
        vec_t v;
        v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.lat = lat; v.wcyc = wcyc; v.wdat = wdat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // hold=1 keeps req_valid high with a conflicting store while the unit is busy.
    task automatic run(input vec_t v, input bit hold);
        int a, nw, wc;
        logic [31:0] wd;
        bit got;
        exp_t e;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wen = v.wen; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        a = cyc;
        sb.push_back('{v.rdata, v.err, v.lat});
        @(posedge clk);
        #1;
        if (hold) begin
            req_wen = 1'b1; req_funct3 = LSU_W; req_wdata = 32'h0;
        end else begin
            req_valid = 1'b0;
        end
        nw = 0; wc = 0; wd = 32'h0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (dmem_wen) begin
                nw++; wc = cyc - a; wd = dmem_wdata;
            end
            if (resp_valid) begin
                got = 1;
                req_valid = 1'b0;
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 32'(resp_err), 32'(e.err));
                check("resp_latency", 32'(cyc - a), 32'(e.lat));
                check("dmem_addr", dmem_addr, {v.addr[31:2], 2'b00});
            end
        end
        if (!got) begin
            check("resp_timeout", 32'd1, 32'd0);
            sb.delete();
            req_valid = 1'b0;
        end
        check("dmem_wen_count", 32'(nw), (v.wcyc != 0) ? 32'd1 : 32'd0);
        if (v.wcyc != 0) begin
            check("dmem_wen_cycle", 32'(wc), 32'(v.wcyc));
            check("dmem_wdata", wd, v.wdat);
        end
    endtask

    vec_t tbl[$];
    int   nwen_rst;

    initial begin
        // reset-state checks while rst_n is held low
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_dmem_wen", 32'(dmem_wen), 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //          wen   f3      addr      wdata         rdata         err lat wcyc wdat
        tbl.push_back(mk(1'b1, LSU_W,  32'h40, 32'h8899AABB, 32'h0,        0, 2, 1, 32'h8899AABB));
        tbl.push_back(mk(1'b1, LSU_W,  32'h44, 32'h0000807F, 32'h0,        0, 2, 1, 32'h0000807F));
        tbl.push_back(mk(1'b1, LSU_W,  32'h48, 32'h11223344, 32'h0,        0, 2, 1, 32'h11223344));
        tbl.push_back(mk(1'b0, LSU_B,  32'h41, 32'h0,        32'hFFFFFFAA, 0, 3, 0, 32'h0));
        tbl.push_back(mk(1'b0, LSU_HU, 32'h42, 32'h0,        32'h00008899, 0, 3, 0, 32'h0));
        tbl.push_back(mk(1'b0, LSU_W,  32'h40, 32'h0,        32'h8899AABB, 0, 3, 0, 32'h0));
        tbl.push_back(mk(1'b0, LSU_BU, 32'h40, 32'h0,        32'h000000BB, 0, 3, 0, 32'h0));
        tbl.push_back(mk(1'b0, LSU_H,  32'h40, 32'h0,        32'hFFFFAABB, 0, 3, 0, 32'h0));
        tbl.push_back(mk(1'b0, LSU_B,  32'h44, 32'h0,        32'h0000007F, 0, 3, 0, 32'h0));
        tbl.push_back(mk(1'b0, LSU_B,  32'h45, 32'h0,        32'hFFFFFF80, 0, 3, 0, 32'h0));
        tbl.push_back(mk(1'b1, LSU_B,  32'h43, 32'h123456CC, 32'h0,        0, 4, 3, 32'hCC99AABB));
        tbl.push_back(mk(1'b0, LSU_W,  32'h40, 32'h0,        32'hCC99AABB, 0, 3, 0, 32'h0));
        tbl.push_back(mk(1'b1, LSU_H,  32'h40, 32'hFFFF1234, 32'h0,        0, 4, 3, 32'hCC991234));
        tbl.push_back(mk(1'b0, LSU_W,  32'h40, 32'h0,        32'hCC991234, 0, 3, 0, 32'h0));
        tbl.push_back(mk(1'b1, LSU_W,  32'h40, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF));
        tbl.push_back(mk(1'b0, LSU_W,  32'h40, 32'h0,        32'hDEADBEEF, 0, 3, 0, 32'h0));
        tbl.push_back(mk(1'b0, LSU_W,  32'h42, 32'h0,        32'h0,        1, 1, 0, 32'h0));
        tbl.push_back(mk(1'b1, LSU_H,  32'h41, 32'h5555,     32'h0,        1, 1, 0, 32'h0));
        tbl.push_back(mk(1'b0, 3'b011, 32'h40, 32'h0,        32'h0,        1, 1, 0, 32'h0));
        tbl.push_back(mk(1'b1, LSU_BU, 32'h40, 32'h77,       32'h0,        1, 1, 0, 32'h0));
        tbl.push_back(mk(1'b0, LSU_HU, 32'h43, 32'h0,        32'h0,        1, 1, 0, 32'h0));

        foreach (tbl[i]) run(tbl[i], 1'b0);

        // requests presented while busy must be ignored
        run(mk(1'b0, LSU_W, 32'h44, 32'h0, 32'h0000807F, 0, 3, 0, 32'h0), 1'b1);
        check("busy_store_ignored", mem[8'h11], 32'h0000807F);

        // reset in the middle of an SB read phase abandons the write
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = LSU_B;
        req_addr = 32'h48; req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_dmem_wen", 32'(dmem_wen), 32'd0);
        check("midrst_dmem_addr", dmem_addr, 32'd0);
        check("midrst_dmem_wdata", dmem_wdata, 32'd0);
        nwen_rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (dmem_wen) nwen_rst++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (dmem_wen) nwen_rst++;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_no_wen", 32'(nwen_rst), 32'd0);
        check("midrst_mem_kept", mem[8'h12], 32'h11223344);
        run(mk(1'b0, LSU_W, 32'h48, 32'h0, 32'h11223344, 0, 3, 0, 32'h0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: cycles from a stable dmem_addr to valid dmem_rdata; legal values 1..4.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1: core access request.
REQ-005 SHALL have port req_ready, output, 1: block can accept a request.
REQ-006 SHALL have port req_wen, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3: RISC-V load/store funct3 (B, H, W, BU, HU).
REQ-008 SHALL have port req_addr, input, WORD_LEN: byte address.
REQ-009 SHALL have port req_wdata, input, WORD_LEN: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, WORD_LEN: extended load data; 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1: misaligned access or illegal funct3; qualified by resp_valid.
REQ-013 SHALL have ports dmem_addr (out, WORD_LEN), dmem_rdata (in, WORD_LEN), dmem_wen (out, 1) and dmem_wdata (out, WORD_LEN): word-wide synchronous data-memory port, word index addr[WORD_LEN-1:2].

Function
REQ-014 SHALL use FSM states IDLE, RD_WAIT, WRITE and RESP; req_ready SHALL equal (state==IDLE).
REQ-015 SHALL accept a request in cycle A, when req_valid && req_ready, and latch wen, funct3, addr and wdata.
REQ-016 SHALL go IDLE->RESP at accept, with resp_err=1, when the access is misaligned (H/HU with addr[0]!=0; W with addr[1:0]!=0) or the funct3 is illegal (loads 011/110/111; stores other than 000-010); no dmem_wen is issued in that case.
REQ-017 SHALL drive dmem_addr={addr[WORD_LEN-1:2],2'b00} from cycle A+1 until the state returns to IDLE; dmem_addr SHALL hold its last value while IDLE.
REQ-018 SHALL complete a load (LB/LH/LW/LBU/LHU) in RD_WAIT, with a down-counter loaded with RD_LAT; dmem_rdata SHALL be sampled in cycle A+RD_LAT+1 and resp_valid SHALL pulse in cycle A+RD_LAT+2.
REQ-019 SHALL select the load lane little-endian, byte lane = addr[1:0] and half lane = addr[1]; B/H SHALL sign-extend and BU/HU SHALL zero-extend to WORD_LEN.
REQ-020 SHALL complete SW without a read: IDLE->WRITE, dmem_wen=1 and dmem_wdata=wdata in cycle A+1 only, resp_valid in cycle A+2.
REQ-021 SHALL complete SB/SH as read-modify-write: RD_WAIT as for a load, then WRITE in cycle A+RD_LAT+2 with only the addressed byte/half replaced by wdata[7:0]/wdata[15:0] and the other bytes preserved; resp_valid SHALL pulse in cycle A+RD_LAT+3.
REQ-022 SHALL assert dmem_wen for exactly one cycle per store and never outside WRITE.
REQ-023 SHALL return from RESP to IDLE unconditionally, so that a new request is accepted no earlier than the cycle after resp_valid.
REQ-024 SHALL ignore req_* inputs while req_ready=0 and keep no request queue.

Reset
REQ-025 SHALL, on rst_n low, immediately set state=IDLE, dmem_wen=0, resp_valid=0, resp_err=0, resp_rdata=0, dmem_addr=0, dmem_wdata=0 and counter=0, including mid-operation; a pending RMW is abandoned with no write.
REQ-026 SHALL drive req_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-027 SHALL take WORD_LEN and the funct3 codes (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) from consts.vh; the state encodings SHALL be local.
REQ-028 SHALL place lane extraction and merge in one combinational sub-module, lsu_lane (inputs funct3, addr[1:0], word, wdata; outputs load value, merged word).

Verification (RD_LAT=1, memory model of the team's 1-cycle-read data memory)
REQ-029 SHALL cover: mem[0x10]=0x8899AABB, LB at 0x41 -> resp_rdata=0xFFFFFFAA in cycle A+3, resp_err=0.
REQ-030 SHALL cover: LHU at 0x42 on the same word -> 0x00008899; LW at 0x40 -> 0x8899AABB.
REQ-031 SHALL cover: SB wdata=0x123456CC at 0x43 -> single dmem_wen in cycle A+3 with dmem_wdata=0xCC99AABB; resp_valid in cycle A+4.
REQ-032 SHALL cover: SW 0xDEADBEEF at 0x40 -> dmem_wen in cycle A+1, resp_valid in cycle A+2; a following LW returns 0xDEADBEEF.
REQ-033 SHALL cover: LW at 0x42 and SH at 0x41 -> resp_valid with resp_err=1 in cycle A+1, no dmem_wen, resp_rdata=0.
REQ-034 SHALL cover: rst_n pulled low during RD_WAIT of an SB -> no dmem_wen, memory unchanged, req_ready=1 after release.
